rx_crc_checker_param: RTL and testbench
=======================================

// Module: rx_crc_checker_param
// PURPOSE
//  Parametrised receive-side FCS checker; next generation of the fixed 64-bit checker in rx_engine.
//  Accumulates CRC-32 over a framed byte stream of DATA_W bits per beat, honours partial last beats,
//  and issues one good/bad verdict pulse per frame at fixed latency. Adds abort handling,
//  back-to-back frame support and saturating frame-statistics counters.
//  Sits between the rx lane aligner/terminator detect and the rx control FSM.
// PARAMETERS
//  DATA_W   64            beat width in bits; legal 32 or 64 (BYTES = DATA_W/8)
//  CNT_W    16            width of each statistics counter
//  RESIDUE  32'hC704DD7B  good-frame CRC register value after all bytes, FCS included
// PORTS
//  rxclk        in   1              receive clock
//  reset_n      in   1              asynchronous active-low reset
//  in_valid     in   1              beat qualifier; all other in_* ignored when low
//  in_sof       in   1              first beat of frame (with in_valid)
//  in_eof       in   1              last beat of frame (with in_valid); may coincide with in_sof
//  in_bytes     in   clog2(BYTES)   valid bytes on eof beat, lanes 0..n-1; 0 = all BYTES
//  in_data      in   DATA_W         lane k = bits [8k+7:8k]; lane 0 first on wire
//  in_abort     in   1              discard current frame (PHY error / overflow)
//  stat_clear   in   1              synchronous clear of all counters
//  crc_check_valid    out  1        one-cycle pulse: frame FCS good
//  crc_check_invalid  out  1        one-cycle pulse: frame FCS bad
//  good_cnt     out  CNT_W          saturating count of good frames
//  bad_cnt      out  CNT_W          saturating count of bad frames
//  abort_cnt    out  CNT_W          saturating count of aborted frames
// BEHAVIOUR
//  - Reset: all outputs 0, in_frame=0, crc_acc=32'hFFFFFFFF, pipeline flags 0.
//  - CRC: poly 04C11DB7, init FFFFFFFF, each byte bit-reflected on entry, MSB-first shift, no output
//    inversion; a frame carrying its correct FCS leaves RESIDUE.
//  - Beat accepted when in_valid & (in_sof | in_frame) & !in_abort; beats outside a frame ignored.
//  - crc_next = f(in_sof ? INIT : crc_acc, in_data, n), n = in_eof ? (in_bytes==0 ? BYTES : in_bytes) : BYTES.
//  - Stage A (edge sampling the eof beat): crc_fin <= crc_next, done_a <= 1; crc_acc <= INIT.
//  - Stage B (next edge): exactly one of crc_check_valid/crc_check_invalid high for one cycle
//    (crc_fin == RESIDUE) -> latency 2 rxclk edges from eof beat. Counter increments on same edge.
//  - Back-to-back: sof on the beat right after eof is legal; pipeline never stalls, no verdict lost.
//  - in_sof while in_frame: previous frame aborted (abort_cnt++, no verdict), new frame starts from INIT.
//  - in_abort: in_frame <= 0, crc_acc <= INIT, abort_cnt++ if in_frame or beat has in_sof; overrides
//    sof/eof on same beat. Abort does not cancel a verdict already in stage A/B.
//  - Counters saturate at all-ones; stat_clear wins over a same-cycle increment.
//  - reset_n low mid-frame or mid-pipeline: verdict dropped, nothing counted; async assert, sync release.
// STRUCTURE
//  - Shared include rx_defs.vh: CRC32_POLY, CRC32_INIT, CRC32_RESIDUE constants, clog2 function.
//  - One sub-module: crc32_var_bytes (combinational) -- crc_in, data, nbytes -> crc_out; unrolled
//    byte-serial chain over BYTES lanes, selecting the tap after byte n.
//  - Top: in_frame flag, crc_acc, stage A/B regs, three counters.
// TESTING
//  1 DATA_W=64: "123456789" + FCS 26 39 F4 CB (13 bytes, beats 8+5, in_bytes=5) -> valid pulse 2 edges
//    after eof beat; good_cnt=1.
//  2 Same frame, last FCS byte CB->CA -> crc_check_invalid pulse only; bad_cnt=1.
//  3 Back-to-back good, bad, good frames, sof on beat after each eof -> valid, invalid, valid on
//    consecutive verdict slots; good_cnt=2, bad_cnt=1.
//  4 in_abort on beat 1 of a 3-beat frame, then good frame -> no pulse for first, abort_cnt=1,
//    second frame valid.
//  5 CNT_W=2: 5 good frames -> good_cnt stays 3; stat_clear with verdict same cycle -> 0.
//  6 DATA_W=32 rerun of 1 (beats 4+4+4+1, in_bytes=1) -> valid; reset_n low between eof and
//    verdict -> no pulse, counters 0.

Source files
------------

// File: rtl/rx_crc_checker_param_pkg.sv
// Shared CRC-32 constants and the single-byte update used by the receive FCS checker.
package rx_crc_checker_param_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // Advance the CRC register by one byte; the byte enters LSB first (bit-reflected),
    // while the register itself shifts MSB first.
    function automatic logic [31:0] crcByte(input logic [31:0] crcIn, input logic [7:0] dataByte);
        logic [31:0] c;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ dataByte[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_crc_checker_param_crc32_var_bytes.sv
// Combinational CRC-32 over the first nbytes lanes of a beat (lane 0 first on the wire).
module crc32_var_bytes
    import rx_crc_checker_param_pkg::*;
#(
    parameter int BYTES = 8,
    parameter int NB_W  = 4
) (
    input  logic [31:0]        crc_in_i,
    input  logic [8*BYTES-1:0] data_i,
    input  logic [NB_W-1:0]    nbytes_i,
    output logic [31:0]        crc_out_o
);

    // Unrolled byte chain; the output takes the tap right after byte nbytes_i.
    always_comb begin
        logic [31:0] chain;
        chain     = crc_in_i;
        crc_out_o = crc_in_i;
        for (int k = 0; k < BYTES; k++) begin
            chain = crcByte(chain, data_i[8*k +: 8]);
            if (nbytes_i == NB_W'(k + 1)) begin
                crc_out_o = chain;
            end
        end
    end

endmodule

// File: rtl/rx_crc_checker_param.sv
// Receive-side FCS checker: accumulates CRC-32 per frame, issues one good/bad pulse per frame
// two rxclk edges after the eof beat, and keeps saturating good/bad/abort frame counters.
module rx_crc_checker_param
    import rx_crc_checker_param_pkg::*;
#(
    parameter int          DATA_W  = 64,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic                            rxclk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic                            in_eof,
    input  logic [$clog2(DATA_W/8)-1:0]     in_bytes,
    input  logic [DATA_W-1:0]               in_data,
    input  logic                            in_abort,
    input  logic                            stat_clear,
    output logic                            crc_check_valid,
    output logic                            crc_check_invalid,
    output logic [CNT_W-1:0]                good_cnt,
    output logic [CNT_W-1:0]                bad_cnt,
    output logic [CNT_W-1:0]                abort_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int NB_W  = $clog2(BYTES) + 1;

    logic             inFrame_q;
    logic [31:0]      crcAcc_q;
    logic [31:0]      crcFin_q;
    logic             doneA_q;
    logic             validB_q;
    logic             invalidB_q;
    logic [CNT_W-1:0] goodCnt_q;
    logic [CNT_W-1:0] badCnt_q;
    logic [CNT_W-1:0] abortCnt_q;

    logic             beatAccept;
    logic             abortEvent;
    logic             finMatch;
    logic [NB_W-1:0]  nbytes;
    logic [31:0]      crcSeed;
    logic [31:0]      crcNext;

    assign beatAccept = in_valid & (in_sof | inFrame_q) & ~in_abort;
    assign abortEvent = in_valid & ((in_abort & (inFrame_q | in_sof)) | (~in_abort & in_sof & inFrame_q));
    assign finMatch   = (crcFin_q == RESIDUE);
    assign crcSeed    = in_sof ? CRC32_INIT : crcAcc_q;

    // Number of lanes contributing to the CRC on this beat; in_bytes==0 means a full beat.
    always_comb begin
        nbytes = NB_W'(BYTES);
        if (in_eof && (in_bytes != '0)) begin
            nbytes = {1'b0, in_bytes};
        end
    end

    crc32_var_bytes #(
        .BYTES (BYTES),
        .NB_W  (NB_W)
    ) u_crc (
        .crc_in_i  (crcSeed),
        .data_i    (in_data),
        .nbytes_i  (nbytes),
        .crc_out_o (crcNext)
    );

    // Frame tracking, running CRC and stage A capture of the final CRC on the eof beat.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            inFrame_q <= 1'b0;
            crcAcc_q  <= CRC32_INIT;
            crcFin_q  <= '0;
            doneA_q   <= 1'b0;
        end else begin
            doneA_q <= beatAccept & in_eof;
            if (in_valid && in_abort) begin
                inFrame_q <= 1'b0;
                crcAcc_q  <= CRC32_INIT;
            end else if (beatAccept) begin
                inFrame_q <= ~in_eof;
                if (in_eof) begin
                    crcFin_q <= crcNext;
                    crcAcc_q <= CRC32_INIT;
                end else begin
                    crcAcc_q <= crcNext;
                end
            end
        end
    end

    // Stage B verdict pulses and saturating statistics; clear beats a same-cycle increment.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            validB_q   <= 1'b0;
            invalidB_q <= 1'b0;
            goodCnt_q  <= '0;
            badCnt_q   <= '0;
            abortCnt_q <= '0;
        end else begin
            validB_q   <= doneA_q & finMatch;
            invalidB_q <= doneA_q & ~finMatch;
            if (stat_clear) begin
                goodCnt_q  <= '0;
                badCnt_q   <= '0;
                abortCnt_q <= '0;
            end else begin
                if (doneA_q && finMatch && (goodCnt_q != '1)) begin
                    goodCnt_q <= goodCnt_q + 1'b1;
                end
                if (doneA_q && !finMatch && (badCnt_q != '1)) begin
                    badCnt_q <= badCnt_q + 1'b1;
                end
                if (abortEvent && (abortCnt_q != '1)) begin
                    abortCnt_q <= abortCnt_q + 1'b1;
                end
            end
        end
    end

    assign crc_check_valid   = validB_q;
    assign crc_check_invalid = invalidB_q;
    assign good_cnt          = goodCnt_q;
    assign bad_cnt           = badCnt_q;
    assign abort_cnt         = abortCnt_q;

endmodule

// File: tb/tb_rx_crc_checker_param.sv
// Directed bench for rx_crc_checker_param: a 64-bit instance with wide counters and a
// 32-bit instance with 2-bit counters, driven one after the other from a shared clock.
module tb_rx_crc_checker_param;

    logic clock = 1'b0;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    logic        reset_n64, in_valid64, in_sof64, in_eof64, in_abort64, stat_clear64;
    logic [2:0]  in_bytes64;
    logic [63:0] in_data64;
    logic        valid64, invalid64;
    logic [15:0] good64, bad64, abort64;

    logic        reset_n32, in_valid32, in_sof32, in_eof32, in_abort32, stat_clear32;
    logic [1:0]  in_bytes32;
    logic [31:0] in_data32;
    logic        valid32, invalid32;
    logic [1:0]  good32, bad32, abort32;

    // "123456789" followed by FCS 26 39 F4 CB; upper lanes of the eof beat carry junk.
    localparam logic [63:0] D64_0   = 64'h3837363534333231;
    localparam logic [63:0] D64_1G  = 64'hDEADBECBF4392639;
    localparam logic [63:0] D64_1B  = 64'hDEADBECAF4392639;
    localparam logic [31:0] D32_0   = 32'h34333231;
    localparam logic [31:0] D32_1   = 32'h38373635;
    localparam logic [31:0] D32_2   = 32'hF4392639;
    localparam logic [31:0] D32_3   = 32'hAABBCCCB;

    always #5 clock = ~clock;

    rx_crc_checker_param #(.DATA_W(64), .CNT_W(16)) dut64 (
        .rxclk             (clock),
        .reset_n           (reset_n64),
        .in_valid          (in_valid64),
        .in_sof            (in_sof64),
        .in_eof            (in_eof64),
        .in_bytes          (in_bytes64),
        .in_data           (in_data64),
        .in_abort          (in_abort64),
        .stat_clear        (stat_clear64),
        .crc_check_valid   (valid64),
        .crc_check_invalid (invalid64),
        .good_cnt          (good64),
        .bad_cnt           (bad64),
        .abort_cnt         (abort64)
    );

    rx_crc_checker_param #(.DATA_W(32), .CNT_W(2)) dut32 (
        .rxclk             (clock),
        .reset_n           (reset_n32),
        .in_valid          (in_valid32),
        .in_sof            (in_sof32),
        .in_eof            (in_eof32),
        .in_bytes          (in_bytes32),
        .in_data           (in_data32),
        .in_abort          (in_abort32),
        .stat_clear        (stat_clear32),
        .crc_check_valid   (valid32),
        .crc_check_invalid (invalid32),
        .good_cnt          (good32),
        .bad_cnt           (bad32),
        .abort_cnt         (abort32)
    );

    // Compare one observed value with its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one beat into the 64-bit instance and let the next edge sample it.
    task automatic applyStimulus64(input logic v, input logic s, input logic e,
                                   input logic [2:0] b, input logic [63:0] d, input logic a);
        in_valid64 = v; in_sof64 = s; in_eof64 = e; in_bytes64 = b; in_data64 = d; in_abort64 = a;
        step();
    endtask

    // Drive one beat into the 32-bit instance and let the next edge sample it.
    task automatic applyStimulus32(input logic v, input logic s, input logic e,
                                   input logic [1:0] b, input logic [31:0] d, input logic a);
        in_valid32 = v; in_sof32 = s; in_eof32 = e; in_bytes32 = b; in_data32 = d; in_abort32 = a;
        step();
    endtask

    task automatic frame32Good();
        applyStimulus32(1, 1, 0, 2'd0, D32_0, 0);
        applyStimulus32(1, 0, 0, 2'd0, D32_1, 0);
        applyStimulus32(1, 0, 0, 2'd0, D32_2, 0);
        applyStimulus32(1, 0, 1, 2'd1, D32_3, 0);
    endtask

    logic [63:0] b2bData  [6];
    logic        b2bSof   [6];
    logic        b2bEof   [6];
    logic        b2bValid [8];
    logic        b2bInval [8];

    initial begin
        reset_n64 = 0; in_valid64 = 0; in_sof64 = 0; in_eof64 = 0; in_abort64 = 0;
        stat_clear64 = 0; in_bytes64 = 0; in_data64 = 0;
        reset_n32 = 0; in_valid32 = 0; in_sof32 = 0; in_eof32 = 0; in_abort32 = 0;
        stat_clear32 = 0; in_bytes32 = 0; in_data32 = 0;
        step();
        step();
        reset_n64 = 1;
        reset_n32 = 1;
        step();
        checkOutput("rst64_valid", valid64, 0);
        checkOutput("rst64_invalid", invalid64, 0);
        checkOutput("rst64_cnts", {good64, bad64, abort64}, 0);
        checkOutput("rst32_cnts", {valid32, invalid32, good32, bad32, abort32}, 0);

        // Good 13-byte frame, partial eof beat of 5 bytes.
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 0);
        applyStimulus64(1, 0, 1, 3'd5, D64_1G, 0);
        checkOutput("t1_latency_valid", valid64, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t1_valid", valid64, 1);
        checkOutput("t1_invalid", invalid64, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t1_pulse_end", valid64, 0);
        checkOutput("t1_good_cnt", good64, 1);

        // Same frame with a corrupted last FCS byte.
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 0);
        applyStimulus64(1, 0, 1, 3'd5, D64_1B, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t2_valid", valid64, 0);
        checkOutput("t2_invalid", invalid64, 1);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t2_bad_cnt", bad64, 1);
        checkOutput("t2_good_cnt", good64, 1);

        // Back-to-back good, bad, good; verdicts land on consecutive two-cycle slots.
        b2bData = '{D64_0, D64_1G, D64_0, D64_1B, D64_0, D64_1G};
        b2bSof  = '{1, 0, 1, 0, 1, 0};
        b2bEof  = '{0, 1, 0, 1, 0, 1};
        b2bValid = '{0, 0, 1, 0, 0, 0, 1, 0};
        b2bInval = '{0, 0, 0, 0, 1, 0, 0, 0};
        for (int s = 0; s < 8; s++) begin
            if (s < 6) begin
                applyStimulus64(1, b2bSof[s], b2bEof[s], b2bEof[s] ? 3'd5 : 3'd0, b2bData[s], 0);
            end else begin
                applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
            end
            checkOutput($sformatf("t3_valid_%0d", s), valid64, b2bValid[s]);
            checkOutput($sformatf("t3_invalid_%0d", s), invalid64, b2bInval[s]);
        end
        checkOutput("t3_good_cnt", good64, 3);
        checkOutput("t3_bad_cnt", bad64, 2);

        // Abort on beat 1 of a 3-beat frame; the orphaned eof beat must be ignored.
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 0);
        applyStimulus64(1, 0, 0, 3'd0, D64_1G, 1);
        applyStimulus64(1, 0, 1, 3'd5, D64_1G, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t4_no_pulse_a", {valid64, invalid64}, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t4_no_pulse_b", {valid64, invalid64}, 0);
        checkOutput("t4_abort_cnt", abort64, 1);
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 0);
        applyStimulus64(1, 0, 1, 3'd5, D64_1G, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t4_after_valid", valid64, 1);

        // A new sof while in a frame aborts the old one and restarts the CRC.
        applyStimulus64(1, 1, 0, 3'd0, 64'h0102030405060708, 0);
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 0);
        applyStimulus64(1, 0, 1, 3'd5, D64_1G, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t4b_valid", valid64, 1);
        checkOutput("t4b_abort_cnt", abort64, 2);

        // Single-beat frame: empty payload plus FCS 00 00 00 00, four lanes only.
        applyStimulus64(1, 1, 1, 3'd4, 64'h12345678_00000000, 0);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t4c_short_valid", valid64, 1);

        // Abort with sof right after an eof must not cancel the verdict in flight.
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 0);
        applyStimulus64(1, 0, 1, 3'd5, D64_1G, 0);
        applyStimulus64(1, 1, 0, 3'd0, D64_0, 1);
        checkOutput("t4d_valid_kept", valid64, 1);
        applyStimulus64(0, 0, 0, 3'd0, 64'd0, 0);
        checkOutput("t4d_good_cnt", good64, 7);
        checkOutput("t4d_bad_cnt", bad64, 2);
        checkOutput("t4d_abort_cnt", abort64, 3);

        // 32-bit rerun of the good frame: beats 4+4+4+1.
        frame32Good();
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        checkOutput("t6_valid32", valid32, 1);
        checkOutput("t6_invalid32", invalid32, 0);
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        checkOutput("t6_good32", good32, 1);

        // Full single beat with in_bytes==0 meaning all four lanes.
        applyStimulus32(1, 1, 1, 2'd0, 32'd0, 0);
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        checkOutput("t6_fullbeat_valid", valid32, 1);

        // Saturation of a 2-bit counter after five good frames.
        for (int f = 0; f < 3; f++) begin
            frame32Good();
        end
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        checkOutput("t5_saturated", good32, 3);

        // stat_clear on the verdict edge wins over the increment.
        frame32Good();
        stat_clear32 = 1;
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        stat_clear32 = 0;
        checkOutput("t5_clear_pulse", valid32, 1);
        checkOutput("t5_clear_cnt", good32, 0);

        // Reset between eof and verdict drops the verdict.
        frame32Good();
        reset_n32 = 0;
        #2;
        checkOutput("t6_rst_async", {valid32, good32, bad32, abort32}, 0);
        reset_n32 = 1;
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        checkOutput("t6_rst_no_pulse", {valid32, invalid32}, 0);
        applyStimulus32(0, 0, 0, 2'd0, 32'd0, 0);
        checkOutput("t6_rst_cnts", {good32, bad32, abort32}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
